// File: rtl/vga_obj_sched.sv
// Frame-synchronous object configuration scheduler: software fills shadow registers and commits,
// and the active set is swapped atomically on the next vsync leading edge (or on timeout).
module vga_obj_sched #(
  parameter logic        VSYNC_POL = 1'b0,
  parameter int unsigned TIMEOUT   = 2000000,
  parameter logic [23:0] RST_COLOR = 24'h000000
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [1:0]  wr_addr,
  input  logic [23:0] wr_data,
  input  logic        vga_vsync,
  output logic [23:0] obj_color,
  output logic [10:0] obj_x,
  output logic [9:0]  obj_y,
  output logic        pending,
  output logic        commit_done,
  output logic        timeout_flag,
  output logic [15:0] frame_cnt
);

  localparam int unsigned    CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StPending, StApply} state_t;

  state_t        r_state;
  logic          r_vsync_d;
  logic [CW-1:0] r_tcnt;
  logic [23:0]   r_sh_color, r_color;
  logic [10:0]   r_sh_x, r_x;
  logic [9:0]    r_sh_y, r_y;
  logic          r_pending, r_commit_done, r_timeout_flag;
  logic [15:0]   r_frame_cnt;
  logic          w_fe;
  logic          w_fire;

  assign w_fe     = (vga_vsync == VSYNC_POL) && (r_vsync_d != VSYNC_POL);
  assign wr_ready = (r_state == StIdle);
  assign w_fire   = wr_valid && wr_ready;

  always_ff @(posedge clk100) begin
    if (rst) begin
      r_state        <= StIdle;
      r_vsync_d      <= ~VSYNC_POL;
      r_tcnt         <= '0;
      r_sh_color     <= RST_COLOR;
      r_sh_x         <= '0;
      r_sh_y         <= '0;
      r_color        <= RST_COLOR;
      r_x            <= '0;
      r_y            <= '0;
      r_pending      <= 1'b0;
      r_commit_done  <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_frame_cnt    <= '0;
    end else begin
      r_vsync_d     <= vga_vsync;
      r_commit_done <= 1'b0;
      if (w_fe) r_frame_cnt <= r_frame_cnt + 16'd1;
      case (r_state)
        StIdle: begin
          if (w_fire) begin
            case (wr_addr)
              2'd0: r_sh_color <= wr_data;
              2'd1: r_sh_x     <= wr_data[10:0];
              2'd2: r_sh_y     <= wr_data[9:0];
              default: begin
                if (wr_data[2]) r_timeout_flag <= 1'b0;
                // Immediate is only meaningful together with commit.
                if (wr_data[0]) begin
                  if (wr_data[1]) begin
                    r_state <= StApply;
                  end else begin
                    r_state   <= StPending;
                    r_pending <= 1'b1;
                  end
                end
              end
            endcase
          end
        end
        StPending: begin
          // A frame edge coinciding with expiry wins, so the flag stays clear.
          if (w_fe || (r_tcnt == TMAX)) begin
            r_state   <= StApply;
            r_pending <= 1'b0;
            if (!w_fe) r_timeout_flag <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + CW'(1);
          end
        end
        StApply: begin
          r_color       <= r_sh_color;
          r_x           <= r_sh_x;
          r_y           <= r_sh_y;
          r_commit_done <= 1'b1;
          r_tcnt        <= '0;
          r_state       <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign obj_color    = r_color;
  assign obj_x        = r_x;
  assign obj_y        = r_y;
  assign pending      = r_pending;
  assign commit_done  = r_commit_done;
  assign timeout_flag = r_timeout_flag;
  assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_vga_obj_sched.sv
// Self-checking bench for vga_obj_sched: directed scenarios plus randomized commits checked
// against a transaction-level model of shadow/active sets, frame edges and timeout expiry.
module tb_vga_obj_sched;

  localparam int unsigned TO = 16;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_addr;
  logic [23:0] wr_data;
  logic        vga_vsync;
  logic [23:0] obj_color;
  logic [10:0] obj_x;
  logic [9:0]  obj_y;
  logic        pending;
  logic        commit_done;
  logic        timeout_flag;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic [23:0] m_sh_color, m_color;
  logic [10:0] m_sh_x, m_x;
  logic [9:0]  m_sh_y, m_y;
  logic [15:0] m_fcnt;
  logic        m_vs_prev;
  logic        m_fe;

  vga_obj_sched #(
    .VSYNC_POL(1'b0),
    .TIMEOUT  (TO),
    .RST_COLOR(24'h000000)
  ) dut (
    .clk100      (clk100),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .vga_vsync   (vga_vsync),
    .obj_color   (obj_color),
    .obj_x       (obj_x),
    .obj_y       (obj_y),
    .pending     (pending),
    .commit_done (commit_done),
    .timeout_flag(timeout_flag),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk100 = ~clk100;

  // One clock edge; the model tracks frame edges from the vsync level history.
  task automatic tick();
    m_fe = !rst && (vga_vsync == 1'b0) && (m_vs_prev != 1'b0);
    @(posedge clk100);
    if (rst) begin
      m_fcnt    = 16'd0;
      m_vs_prev = 1'b1;
    end else begin
      if (m_fe) m_fcnt = m_fcnt + 16'd1;
      m_vs_prev = vga_vsync;
    end
    #1;
  endtask

  task automatic model_apply();
    m_color = m_sh_color;
    m_x     = m_sh_x;
    m_y     = m_sh_y;
  endtask

  task automatic model_reset();
    m_sh_color = 24'h0; m_color = 24'h0;
    m_sh_x     = 11'h0; m_x     = 11'h0;
    m_sh_y     = 10'h0; m_y     = 10'h0;
  endtask

  // Drive one write, holding it until accepted (bounded).
  task automatic wr(input logic [1:0] a, input logic [23:0] d);
    bit ok;
    ok       = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (wr_ready === 1'b1) begin
        ok = 1'b1;
        case (a)
          2'd0: m_sh_color = d;
          2'd1: m_sh_x     = d[10:0];
          2'd2: m_sh_y     = d[9:0];
          default: ;
        endcase
      end
      tick();
    end
    wr_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL write_accept addr=%0d got not accepted exp accepted", a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 24'h0; vga_vsync = 1'b1;
    m_vs_prev = 1'b1; m_fcnt = 16'd0;
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    n_cmp++; if (obj_color !== 24'h000000) begin n_bad++; $display("FAIL reset_color got %h exp %h", obj_color, 24'h0); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", wr_ready); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_fcnt got %0d exp 0", frame_cnt); end
    n_cmp++; if ({pending, commit_done, timeout_flag} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b exp 000", {pending, commit_done, timeout_flag}); end
    n_cmp++; if ({obj_x, obj_y} !== 21'd0) begin n_bad++; $display("FAIL reset_xy got %0d/%0d exp 0/0", obj_x, obj_y); end
  endtask

  task automatic test_normal_commit();
    wr(2'd0, 24'hFF8000);
    wr(2'd1, 24'hABC140);   // upper bits ignored -> 320
    wr(2'd2, 24'h1230F0);   // upper bits ignored -> 240
    wr(2'd3, 24'd1);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (obj_color !== m_color || pending !== 1'b1 || commit_done !== 1'b0) begin
        n_bad++; $display("FAIL normal_hold got col=%h pend=%b done=%b exp col=%h pend=1 done=0", obj_color, pending, commit_done, m_color);
      end
      tick();
    end
    vga_vsync = 1'b0;
    tick();
    n_cmp++; if (obj_color !== m_color) begin n_bad++; $display("FAIL normal_n1 got %h exp %h", obj_color, m_color); end
    tick();
    model_apply();
    n_cmp++; if (obj_color !== 24'hFF8000 || obj_color !== m_color) begin n_bad++; $display("FAIL normal_color got %h exp %h", obj_color, m_color); end
    n_cmp++; if (obj_x !== 11'd320 || obj_y !== 10'd240) begin n_bad++; $display("FAIL normal_xy got %0d/%0d exp 320/240", obj_x, obj_y); end
    n_cmp++; if (commit_done !== 1'b1 || pending !== 1'b0) begin n_bad++; $display("FAIL normal_done got done=%b pend=%b exp 1/0", commit_done, pending); end
    n_cmp++; if (frame_cnt !== m_fcnt) begin n_bad++; $display("FAIL normal_fcnt got %0d exp %0d", frame_cnt, m_fcnt); end
    tick();
    n_cmp++; if (commit_done !== 1'b0) begin n_bad++; $display("FAIL normal_pulse got %b exp 0", commit_done); end
  endtask

  task automatic test_backpressure();
    wr(2'd3, 24'd1);
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 24'h0000FF;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_pend got %b exp 0", wr_ready); end
      tick();
    end
    vga_vsync = 1'b1; tick();
    vga_vsync = 1'b0; tick();
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_apply got %b exp 0", wr_ready); end
    tick();
    model_apply();
    n_cmp++; if (wr_ready !== 1'b1 || commit_done !== 1'b1 || obj_color !== m_color) begin
      n_bad++; $display("FAIL bp_after got rdy=%b done=%b col=%h exp 1/1/%h", wr_ready, commit_done, obj_color, m_color);
    end
    tick();
    m_sh_color = 24'h0000FF;
    wr_valid = 1'b0;
    n_cmp++; if (obj_color !== 24'hFF8000) begin n_bad++; $display("FAIL bp_active got %h exp %h", obj_color, 24'hFF8000); end
  endtask

  task automatic test_immediate();
    wr(2'd3, 24'd3);
    n_cmp++; if (obj_color !== m_color || commit_done !== 1'b0) begin n_bad++; $display("FAIL imm_m1 got col=%h done=%b exp %h/0", obj_color, commit_done, m_color); end
    tick();
    model_apply();
    n_cmp++; if (obj_color !== 24'h0000FF || commit_done !== 1'b1) begin n_bad++; $display("FAIL imm_m2 got col=%h done=%b exp 0000ff/1", obj_color, commit_done); end
  endtask

  task automatic test_timeout();
    int k, npend;
    vga_vsync = 1'b1; tick();
    wr(2'd0, 24'h5A5A5A);
    wr(2'd3, 24'd1);
    k = 0; npend = 0;
    while (commit_done !== 1'b1 && k < 40) begin
      if (pending === 1'b1) npend++;
      tick();
      k++;
    end
    model_apply();
    n_cmp++; if (npend != TO) begin n_bad++; $display("FAIL to_pend_cycles got %0d exp %0d", npend, TO); end
    n_cmp++; if (k != TO + 1) begin n_bad++; $display("FAIL to_latency got %0d exp %0d", k, TO + 1); end
    n_cmp++; if (timeout_flag !== 1'b1 || obj_color !== m_color) begin n_bad++; $display("FAIL to_apply got flag=%b col=%h exp 1/%h", timeout_flag, obj_color, m_color); end
    tick();
    n_cmp++; if (timeout_flag !== 1'b1) begin n_bad++; $display("FAIL to_sticky got %b exp 1", timeout_flag); end
    wr(2'd3, 24'd4);
    n_cmp++; if (timeout_flag !== 1'b0) begin n_bad++; $display("FAIL to_clear got %b exp 0", timeout_flag); end
  endtask

  task automatic test_fe_same_cycle();
    wr(2'd0, 24'hC0FFEE);
    wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 24'd1; vga_vsync = 1'b0;
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (pending !== 1'b1 || commit_done !== 1'b0) begin n_bad++; $display("FAIL same_fe_wait got pend=%b done=%b exp 1/0", pending, commit_done); end
      tick();
    end
    n_cmp++; if (frame_cnt !== m_fcnt) begin n_bad++; $display("FAIL same_fe_fcnt got %0d exp %0d", frame_cnt, m_fcnt); end
    vga_vsync = 1'b1; tick();
    vga_vsync = 1'b0; tick();
    tick();
    model_apply();
    n_cmp++; if (commit_done !== 1'b1 || obj_color !== m_color) begin n_bad++; $display("FAIL same_fe_apply got done=%b col=%h exp 1/%h", commit_done, obj_color, m_color); end
  endtask

  task automatic test_fe_timeout_tie();
    vga_vsync = 1'b1; tick();
    wr(2'd0, 24'h13579B);
    wr(2'd3, 24'd1);
    for (int i = 0; i < TO - 1; i++) tick();
    vga_vsync = 1'b0;
    tick();
    tick();
    model_apply();
    n_cmp++; if (commit_done !== 1'b1 || obj_color !== m_color) begin n_bad++; $display("FAIL tie_apply got done=%b col=%h exp 1/%h", commit_done, obj_color, m_color); end
    n_cmp++; if (timeout_flag !== 1'b0) begin n_bad++; $display("FAIL tie_flag got %b exp 0", timeout_flag); end
  endtask

  task automatic test_random();
    bit imm, exp_to;
    for (int it = 0; it < 30; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        vga_vsync = 1'($urandom);
        wr(2'($urandom_range(0, 2)), 24'($urandom));
      end
      imm = 1'($urandom);
      vga_vsync = 1'($urandom);
      wr(2'd3, imm ? 24'd7 : 24'd5);
      exp_to = 1'b0;
      if (!imm) begin
        for (int k = 1; k <= int'(TO); k++) begin
          n_cmp++; if (pending !== 1'b1 || obj_color !== m_color) begin
            n_bad++; $display("FAIL rnd_wait it=%0d got pend=%b col=%h exp 1/%h", it, pending, obj_color, m_color);
          end
          if ($urandom_range(0, 5) == 0) vga_vsync = ~vga_vsync;
          tick();
          if (m_fe) break;
          if (k == int'(TO)) exp_to = 1'b1;
        end
      end
      n_cmp++; if (commit_done !== 1'b0) begin n_bad++; $display("FAIL rnd_early it=%0d got %b exp 0", it, commit_done); end
      tick();
      model_apply();
      n_cmp++; if (obj_color !== m_color || obj_x !== m_x || obj_y !== m_y || commit_done !== 1'b1) begin
        n_bad++; $display("FAIL rnd_apply it=%0d got %h/%0d/%0d/%b exp %h/%0d/%0d/1", it, obj_color, obj_x, obj_y, commit_done, m_color, m_x, m_y);
      end
      n_cmp++; if (timeout_flag !== exp_to || frame_cnt !== m_fcnt) begin
        n_bad++; $display("FAIL rnd_status it=%0d got to=%b fc=%0d exp %b/%0d", it, timeout_flag, frame_cnt, exp_to, m_fcnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    vga_vsync = 1'b1; tick();
    wr(2'd0, 24'($urandom) | 24'h1);
    wr(2'd3, 24'd1);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    n_cmp++; if (obj_color !== 24'h0 || obj_x !== 11'd0 || obj_y !== 10'd0) begin n_bad++; $display("FAIL mid_rst_obj got %h/%0d/%0d exp 0/0/0", obj_color, obj_x, obj_y); end
    n_cmp++; if (pending !== 1'b0 || wr_ready !== 1'b1 || frame_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_rst_state got pend=%b rdy=%b fc=%0d exp 0/1/0", pending, wr_ready, frame_cnt); end
    vga_vsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (commit_done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_discard got %b exp 0", commit_done); end
    end
    wr(2'd3, 24'd3);
    tick();
    model_apply();
    n_cmp++; if (obj_color !== m_color || commit_done !== 1'b1) begin n_bad++; $display("FAIL mid_rst_shadow got %h/%b exp %h/1", obj_color, commit_done, m_color); end
  endtask

  task automatic test_frame_wrap();
    logic [15:0] start;
    start = m_fcnt;
    for (int i = 0; i < 65536; i++) begin
      vga_vsync = 1'b1; tick();
      vga_vsync = 1'b0; tick();
      if (m_fcnt == 16'd0) begin
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL wrap_zero got %0d exp 0", frame_cnt); end
      end
    end
    n_cmp++; if (frame_cnt !== m_fcnt || frame_cnt !== start) begin n_bad++; $display("FAIL wrap_end got %0d exp %0d", frame_cnt, start); end
  endtask

  initial begin
    test_reset();
    test_normal_commit();
    test_backpressure();
    test_immediate();
    test_timeout();
    test_fe_same_cycle();
    test_fe_timeout_tie();
    test_random();
    test_reset_mid();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
